// File: rtl/usb_kbd_event_queue_if.sv
// usb_kbd_event_queue_if: valid/ready pop port carrying one make/break key event
interface usb_kbd_event_queue_if;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_make;
  logic [7:0] ev_code;
  modport master (output ev_valid, ev_make, ev_code, input ev_ready);
  modport slave  (input ev_valid, ev_make, ev_code, output ev_ready);
endinterface

// File: rtl/usb_kbd_event_queue.sv
// usb_kbd_event_queue: diffs successive HID keyboard reports into make/break events queued in a FWFT FIFO
module usb_kbd_event_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  usbclk,
  input  logic                  usbrst,
  input  logic [1:0]            typ,
  input  logic                  report,
  input  logic [7:0]            key_modifiers,
  input  logic [7:0]            key1,
  input  logic [7:0]            key2,
  input  logic [7:0]            key3,
  input  logic [7:0]            key4,
  input  logic                  conerr,
  usb_kbd_event_queue_if.master ev,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE, BREAK, MAKE, MOD, COMMIT} state_t;
  state_t r_state;
  logic [2:0] r_idx;
  logic [7:0] r_prev_mod, r_cur_mod, r_pend_mod;
  logic [3:0][7:0] r_prev_key, r_cur_key, r_pend_key;
  logic r_pflag, r_rel_sent, r_overflow;
  logic [DEPTH_LOG2:0] r_wp, r_rp;
  logic [8:0] r_mem [2**DEPTH_LOG2];
  logic [3:0][7:0] w_in_key, w_new_key;
  logic [7:0] w_new_mod, w_bk, w_mk;
  logic [8:0] w_ev, w_head;
  logic w_roll, w_acc, w_rel, w_take, w_b_ok, w_m_ok, w_req, w_full, w_push, w_pop, w_last;
  assign w_in_key = {key4, key3, key2, key1};
  assign w_acc = report & (typ == 2'd1) & ~w_roll;
  // The synthetic release snapshot is sent once per non-zero prev and wins over a simultaneous report
  assign w_rel = (conerr | (typ != 2'd1)) & ({r_prev_mod, r_prev_key} != '0) & ~r_rel_sent;
  assign w_take = w_acc | w_rel;
  assign w_new_mod = w_rel ? '0 : key_modifiers;
  assign w_new_key = w_rel ? '0 : w_in_key;
  assign w_bk = r_prev_key[r_idx[1:0]];
  assign w_mk = r_cur_key[r_idx[1:0]];
  always_comb begin
    w_roll = 1'b0;
    w_b_ok = w_bk != 8'h00;
    w_m_ok = w_mk != 8'h00;
    for (int m = 0; m < 4; m++) begin
      if (w_in_key[m] != 8'h00 && w_in_key[m] < 8'h04) w_roll = 1'b1;
      if (w_bk == r_cur_key[m] || (3'(m) < r_idx && w_bk == r_prev_key[m])) w_b_ok = 1'b0;
      if (w_mk == r_prev_key[m] || (3'(m) < r_idx && w_mk == r_cur_key[m])) w_m_ok = 1'b0;
    end
  end
  assign w_req = (r_state == BREAK & w_b_ok) | (r_state == MAKE & w_m_ok) |
                 (r_state == MOD & (r_prev_mod[r_idx] != r_cur_mod[r_idx]));
  assign w_ev = r_state == BREAK ? {1'b0, w_bk} :
                r_state == MAKE  ? {1'b1, w_mk} : {r_cur_mod[r_idx], 5'b11100, r_idx};
  assign w_last = r_state == MOD ? r_idx == 3'd7 : r_idx == 3'd3;
  assign level = r_wp - r_rp;
  assign w_full = level[DEPTH_LOG2];
  assign w_push = w_req & ~w_full;
  assign w_pop = ev.ev_valid & ev.ev_ready;
  assign w_head = r_mem[r_rp[DEPTH_LOG2-1:0]];
  assign ev.ev_valid = level != '0;
  assign ev.ev_make = ev.ev_valid & w_head[8];
  assign ev.ev_code = ev.ev_valid ? w_head[7:0] : 8'h00;
  assign overflow = r_overflow;
  assign busy = r_state != IDLE;
  always_ff @(posedge usbclk)
    if (w_push) r_mem[r_wp[DEPTH_LOG2-1:0]] <= w_ev;
  always_ff @(posedge usbclk or posedge usbrst) begin
    if (usbrst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_prev_mod <= '0;
      r_prev_key <= '0;
      r_cur_mod <= '0;
      r_cur_key <= '0;
      r_pend_mod <= '0;
      r_pend_key <= '0;
      r_pflag <= 1'b0;
      r_rel_sent <= 1'b0;
      r_overflow <= 1'b0;
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_wp <= r_wp + (DEPTH_LOG2+1)'(w_push);
      r_rp <= r_rp + (DEPTH_LOG2+1)'(w_pop);
      r_overflow <= r_overflow | (w_req & w_full);
      r_rel_sent <= w_rel | (r_rel_sent & ~(r_state == COMMIT & {r_cur_mod, r_cur_key} != '0 & ~w_take & ~r_pflag));
      r_idx <= (w_last | r_state == IDLE | r_state == COMMIT) ? 3'd0 : r_idx + 3'd1;
      if (w_take && r_state != IDLE) begin
        r_pend_mod <= w_new_mod;
        r_pend_key <= w_new_key;
        r_pflag <= 1'b1;
      end
      case (r_state)
        IDLE: if (w_take) begin
          r_cur_mod <= w_new_mod;
          r_cur_key <= w_new_key;
          r_state <= BREAK;
        end
        BREAK: if (w_last) r_state <= MAKE;
        MAKE: if (w_last) r_state <= MOD;
        MOD: if (w_last) r_state <= COMMIT;
        default: begin
          r_prev_mod <= r_cur_mod;
          r_prev_key <= r_cur_key;
          r_pflag <= 1'b0;
          r_cur_mod <= w_take ? w_new_mod : r_pend_mod;
          r_cur_key <= w_take ? w_new_key : r_pend_key;
          r_state <= (w_take | r_pflag) ? BREAK : IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_usb_kbd_event_queue.sv
// tb_usb_kbd_event_queue: directed checks of report diffing, event order, FIFO backpressure and disconnect
module tb_usb_kbd_event_queue;
  logic usbclk = 1'b0;
  logic usbrst = 1'b1;
  logic [1:0] typ = 2'd1;
  logic report = 1'b0;
  logic [7:0] key_modifiers = '0, key1 = '0, key2 = '0, key3 = '0, key4 = '0;
  logic conerr = 1'b0;
  logic [2:0] level;
  logic overflow, busy;
  int total = 0;
  int bad = 0;
  usb_kbd_event_queue_if ev ();
  usb_kbd_event_queue #(.DEPTH_LOG2(2)) dut (
    .usbclk(usbclk), .usbrst(usbrst), .typ(typ), .report(report),
    .key_modifiers(key_modifiers), .key1(key1), .key2(key2), .key3(key3), .key4(key4),
    .conerr(conerr), .ev(ev), .level(level), .overflow(overflow), .busy(busy)
  );
  always #5 usbclk = ~usbclk;
  task automatic tick();
    @(posedge usbclk);
    #1;
  endtask
  task automatic scan();
    repeat (17) tick();
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] m, a, b, c, d);
    key_modifiers = m;
    key1 = a;
    key2 = b;
    key3 = c;
    key4 = d;
    report = 1'b1;
    tick();
    report = 1'b0;
  endtask
  task automatic pop(input string tag, input logic mk, input logic [7:0] cd);
    chk({tag, "_valid"}, 16'(ev.ev_valid), 16'd1);
    chk({tag, "_make"}, 16'(ev.ev_make), 16'(mk));
    chk({tag, "_code"}, 16'(ev.ev_code), 16'(cd));
    ev.ev_ready = 1'b1;
    tick();
    ev.ev_ready = 1'b0;
  endtask
  initial begin
    ev.ev_ready = 1'b0;
    repeat (3) tick();
    usbrst = 1'b0;
    tick();
    chk("rst_valid", 16'(ev.ev_valid), 16'd0);
    chk("rst_make", 16'(ev.ev_make), 16'd0);
    chk("rst_code", 16'(ev.ev_code), 16'h00);
    chk("rst_level", 16'(level), 16'd0);
    chk("rst_ovf", 16'(overflow), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    // press: event pushed at T+5, idle after T+17
    send(8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
    chk("press_busy_T", 16'(busy), 16'd1);
    repeat (4) tick();
    chk("press_valid_T4", 16'(ev.ev_valid), 16'd0);
    tick();
    chk("press_valid_T5", 16'(ev.ev_valid), 16'd1);
    chk("press_code_T5", 16'(ev.ev_code), 16'h04);
    repeat (11) tick();
    chk("press_busy_T16", 16'(busy), 16'd1);
    tick();
    chk("press_busy_T17", 16'(busy), 16'd0);
    chk("press_level", 16'(level), 16'd1);
    pop("press", 1'b1, 8'h04);
    chk("press_level0", 16'(level), 16'd0);
    // release
    send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    scan();
    chk("rel_level", 16'(level), 16'd1);
    pop("rel", 1'b0, 8'h04);
    chk("rel_level0", 16'(level), 16'd0);
    // mixed
    send(8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
    scan();
    pop("mix_pre", 1'b1, 8'h04);
    send(8'h02, 8'h05, 8'h05, 8'h00, 8'h00);
    scan();
    chk("mix_level", 16'(level), 16'd3);
    pop("mix_b04", 1'b0, 8'h04);
    pop("mix_m05", 1'b1, 8'h05);
    pop("mix_mE1", 1'b1, 8'hE1);
    chk("mix_level0", 16'(level), 16'd0);
    send(8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
    scan();
    chk("mix2_level", 16'(level), 16'd3);
    pop("mix2_b05", 1'b0, 8'h05);
    pop("mix2_m04", 1'b1, 8'h04);
    pop("mix2_bE1", 1'b0, 8'hE1);
    // rollover
    send(8'h00, 8'h01, 8'h01, 8'h01, 8'h01);
    chk("roll_busy", 16'(busy), 16'd0);
    scan();
    chk("roll_level", 16'(level), 16'd0);
    send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    scan();
    chk("roll2_level", 16'(level), 16'd1);
    pop("roll2", 1'b0, 8'h04);
    // backpressure: six events into a four-deep FIFO
    send(8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
    scan();
    chk("bp_level", 16'(level), 16'd4);
    chk("bp_ovf", 16'(overflow), 16'd1);
    chk("bp_head", 16'(ev.ev_code), 16'h04);
    tick();
    chk("bp_head_stable", 16'(ev.ev_code), 16'h04);
    pop("bp_04", 1'b1, 8'h04);
    pop("bp_05", 1'b1, 8'h05);
    pop("bp_06", 1'b1, 8'h06);
    pop("bp_07", 1'b1, 8'h07);
    chk("bp_level0", 16'(level), 16'd0);
    chk("bp_ovf_sticky", 16'(overflow), 16'd1);
    // disconnect
    send(8'h01, 8'h04, 8'h00, 8'h00, 8'h00);
    scan();
    chk("dc_pre_level", 16'(level), 16'd4);
    pop("dc_pre_05", 1'b0, 8'h05);
    pop("dc_pre_06", 1'b0, 8'h06);
    pop("dc_pre_07", 1'b0, 8'h07);
    pop("dc_pre_E1", 1'b0, 8'hE1);
    conerr = 1'b1;
    tick();
    chk("dc_busy", 16'(busy), 16'd1);
    scan();
    chk("dc_level", 16'(level), 16'd2);
    pop("dc_04", 1'b0, 8'h04);
    pop("dc_E0", 1'b0, 8'hE0);
    repeat (40) tick();
    chk("dc_hold_level", 16'(level), 16'd0);
    chk("dc_hold_busy", 16'(busy), 16'd0);
    conerr = 1'b0;
    tick();
    // report arriving on the COMMIT edge is processed back-to-back
    send(8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
    repeat (16) tick();
    send(8'h00, 8'h05, 8'h00, 8'h00, 8'h00);
    chk("pend_busy", 16'(busy), 16'd1);
    scan();
    chk("pend_idle", 16'(busy), 16'd0);
    chk("pend_level", 16'(level), 16'd3);
    pop("pend_m04", 1'b1, 8'h04);
    pop("pend_b04", 1'b0, 8'h04);
    pop("pend_m05", 1'b1, 8'h05);
    // reset mid-scan clears everything and yields no release events
    send(8'h00, 8'h06, 8'h00, 8'h00, 8'h00);
    repeat (3) tick();
    chk("mid_level_pre", 16'(level), 16'd1);
    usbrst = 1'b1;
    #1;
    chk("mid_busy", 16'(busy), 16'd0);
    chk("mid_level", 16'(level), 16'd0);
    chk("mid_valid", 16'(ev.ev_valid), 16'd0);
    chk("mid_ovf", 16'(overflow), 16'd0);
    tick();
    usbrst = 1'b0;
    send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    scan();
    chk("post_level", 16'(level), 16'd0);
    chk("post_busy", 16'(busy), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/usb_kbd_event_queue.md
# usb_kbd_event_queue

Downstream consumer of the USB HID host's decoded keyboard outputs. It compares each new keyboard report against the previous one and turns the differences into discrete make/break key events. Events go into a first-word-fall-through FIFO with a valid/ready pop interface. Console, PS/2-emulation and UART-dump logic read keystrokes from this FIFO instead of polling the raw 4-key snapshot.

## Interface
Parameters:
- DEPTH_LOG2, 4: FIFO holds 2^DEPTH_LOG2 events.

Ports:
- usbclk  in  1  12 MHz USB clock, the single clock; all logic on its rising edge
- usbrst  in  1  reset, asynchronous assert, active-high
- typ  in  2  device type from HID host; 1 = keyboard
- report  in  1  one-cycle pulse, new report valid on the inputs below
- key_modifiers  in  8  modifier bitmap (bit0 LCtrl … bit7 RGUI)
- key1, key2, key3, key4  in  8 each  usage codes, 0x00 = empty slot
- conerr  in  1  connection error / device lost
- ev_valid  out  1  FIFO head valid
- ev_ready  in  1  consumer accepts head when ev_valid & ev_ready
- ev_make  out  1  head event: 1 = press, 0 = release
- ev_code  out  8  head usage code; modifiers use 0xE0+bit
- level  out  DEPTH_LOG2+1  FIFO occupancy
- overflow  out  1  sticky; an event was dropped; cleared only by usbrst
- busy  out  1  scan in progress (state ≠ IDLE)

## Operation
- Registers: prev snapshot (mods + 4 keys) and cur snapshot. A one-deep pending slot holds a snapshot plus a flag.
- Accept: report & typ==1 latches the inputs. In IDLE they go to cur; otherwise they go to pending, and the newest report overwrites any older pending one.
- Rollover: if any of key1..key4 is 0x01–0x03, the report is discarded entirely. No events, prev unchanged.
- Release-all:
  - Condition: (conerr==1 or typ≠1) while prev is non-zero.
  - A synthetic all-zero snapshot is queued as a report.
  - It is queued at most once per non-zero prev.
- State machine:
  - IDLE → BREAK(i=0..3) → MAKE(j=0..3) → MOD(b=0..7) → COMMIT → IDLE. One candidate is evaluated per cycle.
  - BREAK i: emit {0, prev.key[i]} if the key is non-zero, absent from cur.key[0..3], and not equal to any prev.key[k<i].
  - MAKE j: emit {1, cur.key[j]} if the key is non-zero, absent from prev.key[0..3], and not equal to any cur.key[k<j].
  - MOD b: emit {cur.mod[b], 0xE0+b} if prev.mod[b] ≠ cur.mod[b].
  - COMMIT: prev ← cur. If pending is set, load cur from pending, clear the flag, and go directly to BREAK(0).
- Event order within one report: all breaks (slot order), then makes, then modifiers from bit0 up.
- FIFO:
  - Push is refused when level == 2^DEPTH_LOG2. This holds even if a pop occurs in the same cycle.
  - A refused event is dropped and sets overflow. The scan still proceeds, and prev is still committed.
  - Pop is accepted on ev_valid & ev_ready. A simultaneous push and pop with a non-full FIFO leaves level unchanged.
  - Read/write pointers are DEPTH_LOG2+1 bits and wrap modulo 2^(DEPTH_LOG2+1).
- Reset mid-scan: prev, cur, pending, FIFO and state are all cleared. No release events are generated on reset.

## Timing
- Reset values:
  - ev_valid=0, ev_make=0, ev_code=0x00
  - level=0, overflow=0, busy=0
  - prev=cur=0, state=IDLE
- A report pulse at edge T in IDLE evaluates the cycles as follows:
  - BREAK at edges T+1..T+4
  - MAKE at edges T+5..T+8
  - MOD at edges T+9..T+16
  - COMMIT at edge T+17
  - IDLE from T+18
- Fixed 17-cycle scan, independent of how many events are emitted.
- A pushed event is visible on ev_valid/ev_code/ev_make in the cycle after the push edge.
- The head is stable while ev_valid & ~ev_ready.
- Pending is picked up at COMMIT with zero idle cycles.
- A report arriving in the same cycle as COMMIT goes to pending and is then processed immediately.
- The HID report rate (≥1 ms = 12000 cycles) far exceeds the 17-cycle scan, so pending overwrite only occurs under artificial stimulus.

## Test plan
- Press: from reset, pulse report with key1=0x04, others 0 → exactly one event {make=1, code=0x04}. ev_valid rises after edge T+5, busy low from T+18.
- Release: follow with key1=0x00 → one event {0, 0x04}. Level returns to 0 after one pop.
- Mixed:
  - Stimulus: prev key1=0x04, mods=0x00; new key1=0x05, key2=0x05, mods=0x02.
  - Required order: {0,0x04}, {1,0x05}, {1,0xE1}. Only one make for the duplicated 0x05.
- Rollover: prev key1=0x04; report with key1..4=0x01 → no events. A subsequent key1=0x00 yields {0, 0x04}.
- Backpressure:
  - Setup: DEPTH_LOG2=2, ev_ready=0; report with four new keys 0x04..0x07 plus mods 0x03 (six events).
  - Required: level=4, overflow=1, FIFO holds makes 0x04..0x07 in order.
  - Then ev_ready=1 → four pops, level 0, overflow stays 1.
- Disconnect: holding key1=0x04, mods=0x01, assert conerr → {0, 0x04} then {0, 0xE0}. No further events while conerr stays high.
